// File: rtl/note_judge_if.sv
// Control and chart-ROM signals of the rhythm judge, seen from the judge (slave)
// and from the control FSM / chart ROM side (master).
interface note_judge_if #(
  parameter int ADDR_W = 6
);
  logic              map_i;
  logic              chance_i;
  logic              master_i;
  logic [3:0]        key_hit_i;
  logic [1:0]        note_lane_i;
  logic              note_rest_i;
  logic [ADDR_W-1:0] note_addr_o;
  logic              miss_o;
  logic              hit_o;
  logic              recover_o;
  logic              done_o;
  logic [ADDR_W:0]   hit_count_o;
  logic [7:0]        combo_o;

  modport slave (
    input  map_i, chance_i, master_i, key_hit_i, note_lane_i, note_rest_i,
    output note_addr_o, miss_o, hit_o, recover_o, done_o, hit_count_o, combo_o
  );

  modport master (
    output map_i, chance_i, master_i, key_hit_i, note_lane_i, note_rest_i,
    input  note_addr_o, miss_o, hit_o, recover_o, done_o, hit_count_o, combo_o
  );
endinterface

// File: rtl/note_judge.sv
// Rhythm judge: walks the song chart one slot at a time and grades player key
// pulses against each note's lane inside the end-of-slot timing window.
module note_judge #(
  parameter int NOTE_COUNT   = 64,
  parameter int ADDR_W       = 6,
  parameter int TICK_DIV     = 50000,
  parameter int NOTE_PERIOD  = 16,
  parameter int HIT_WINDOW   = 4,
  parameter int RECOVER_HITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  note_judge_if.slave   bus
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PHW   = (NOTE_PERIOD > 1) ? $clog2(NOTE_PERIOD) : 1;
  localparam int RW    = $clog2(RECOVER_HITS + 1);
  localparam int WIN_M = ((HIT_WINDOW >> 1) > 0) ? (HIT_WINDOW >> 1) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PHW-1:0]    PHASE_LAST = PHW'(NOTE_PERIOD - 1);
  localparam logic [PHW-1:0]    OPEN_N     = PHW'(NOTE_PERIOD - HIT_WINDOW);
  localparam logic [PHW-1:0]    OPEN_M     = PHW'(NOTE_PERIOD - WIN_M);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NOTE_COUNT - 1);
  localparam logic [RW-1:0]     REC_LAST   = RW'(RECOVER_HITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [PHW-1:0]    phase_q, phase_d;
  logic              judged_q, judged_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              rec_q, rec_d;
  logic [ADDR_W:0]   hcnt_q, hcnt_d;
  logic [7:0]        combo_q, combo_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;

  logic              tick;
  logic              win_open;
  logic              judge;
  logic              key_ok;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    judged_d = judged_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    rec_d    = 1'b0;
    hcnt_d   = hcnt_q;
    combo_d  = combo_q;
    rcnt_d   = bus.chance_i ? rcnt_q : '0;
    tick     = 1'b0;
    win_open = phase_q >= (bus.master_i ? OPEN_M : OPEN_N);
    judge    = 1'b0;
    key_ok   = bus.key_hit_i == (4'b0001 << bus.note_lane_i);

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (bus.map_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        presc_d  = '0;
        phase_d  = '0;
        judged_d = 1'b0;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        tick    = presc_q == PRESC_LAST;
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) phase_d = phase_q + 1'b1;
        judge = !bus.note_rest_i && !judged_q && win_open && (bus.key_hit_i != 4'b0000);
        if (judge) begin
          judged_d = 1'b1;
          hit_d    = key_ok;
          miss_d   = !key_ok;
        end
        // A key graded on the final tick wins over the unjudged-note miss.
        if (tick && phase_q == PHASE_LAST) begin
          if (!bus.note_rest_i && !judged_q && !judge) miss_d = 1'b1;
          if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: ;
    endcase

    if (hit_d) begin
      hcnt_d = hcnt_q + 1'b1;
      if (combo_q != 8'hFF) combo_d = combo_q + 8'd1;
      if (bus.chance_i) begin
        if (rcnt_q == REC_LAST) begin
          rec_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end
    if (miss_d) begin
      combo_d = '0;
      rcnt_d  = '0;
    end
  end

  // Dropping map is a full song abort: same effect as reset, pending pulses lost.
  always_ff @(posedge clk) begin
    if (reset || !bus.map_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      presc_q  <= '0;
      phase_q  <= '0;
      judged_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      rec_q    <= 1'b0;
      hcnt_q   <= '0;
      combo_q  <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      judged_q <= judged_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      rec_q    <= rec_d;
      hcnt_q   <= hcnt_d;
      combo_q  <= combo_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign bus.note_addr_o = addr_q;
  assign bus.miss_o      = miss_q;
  assign bus.hit_o       = hit_q;
  assign bus.recover_o   = rec_q;
  assign bus.done_o      = state_q == S_DONE;
  assign bus.hit_count_o = hcnt_q;
  assign bus.combo_o     = combo_q;

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Rhythm-judging stage sitting directly upstream of the game control FSM.
- While the game map is active, steps through the song chart ROM one note slot at a time and compares debounced player key pulses against each note's lane inside a timing window.
- Produces the one-cycle miss pulses, the recover pulse and the level done flag that the control FSM consumes.
- Also keeps hit and combo counters for the display.

Parameters:
- NOTE_COUNT, 64: number of chart entries per song.
- ADDR_W, 6: chart address width; 2^ADDR_W ≥ NOTE_COUNT.
- TICK_DIV, 50000: clk cycles per timing tick.
- NOTE_PERIOD, 16: ticks per note slot.
- HIT_WINDOW, 4: window width in ticks at the end of each slot (normal mode).
- RECOVER_HITS, 4: consecutive hits needed during a chance window to earn recover.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- map  in  1  high while gameplay is active (from control FSM)
- chance  in  1  recover window open (from control FSM)
- master  in  1  hard mode; halves the hit window
- key_hit  in  4  one-cycle debounced key pulses, one bit per lane
- note_lane  in  2  chart ROM data, lane of the note at note_addr (1-cycle read latency)
- note_rest  in  1  chart ROM data, entry is a rest (not judged)
- note_addr  out  ADDR_W  chart ROM address
- miss  out  1  one-cycle pulse, note missed
- hit  out  1  one-cycle pulse, note hit
- recover  out  1  one-cycle pulse, recovery earned
- done  out  1  level, chart finished; held until map falls
- hit_count  out  ADDR_W+1  hits this song
- combo  out  8  current consecutive hits, saturates at 255

Behaviour:
- **Reset** (synchronous, active-high): state IDLE. note_addr=0, miss=hit=recover=done=0, hit_count=0, combo=0. Prescaler, phase counter and recover counter all cleared.
- **States:**
  - IDLE: outputs quiet, counters hold 0. On map=1 go to FETCH with note_addr=0.
  - FETCH (1 cycle): ROM read in flight. Clear prescaler, phase and the per-note judged flag. Then go to PLAY.
  - PLAY: prescaler counts 0..TICK_DIV-1 and emits a tick on wrap. Phase counts ticks 0..NOTE_PERIOD-1.
  - DONE: done=1. Stay until map=0, then go to IDLE.
- **Hit window:** win = master ? max(HIT_WINDOW>>1,1) : HIT_WINDOW. Window is open when phase ≥ NOTE_PERIOD-win.
- **Judging a note** (note_rest=0, judged=0, window open, key_hit≠0) sets judged=1 and resolves as:
  - key_hit equal to the one-hot of note_lane: hit.
  - Any other pattern (wrong lane, or several keys): miss.
- **Ignored key presses:** outside the window, after the note is judged, or on rest notes.
- **End of slot:** on the tick at phase=NOTE_PERIOD-1:
  - If the note is unjudged and not a rest, it is a miss.
  - If note_addr=NOTE_COUNT-1, go to DONE; otherwise note_addr+1 and go to FETCH.
  - A key judged in the final window cycle takes precedence over the end-of-slot miss.
- **Slot length:** exactly NOTE_PERIOD·TICK_DIV+1 clk cycles.
- **Output pulses:**
  - miss, hit and recover are registered and asserted exactly one cycle after the deciding cycle, one cycle wide.
  - At most one of hit/miss is asserted per slot.
  - After done rises, no further pulses are emitted.
- **Counters:**
  - On hit: hit_count+1, combo+1 (saturating at 255).
  - On miss: combo=0.
- **Recover:**
  - While chance=1, each hit increments the recover counter. On reaching RECOVER_HITS, pulse recover and clear the counter.
  - The recover counter is cleared on any miss or whenever chance=0.
- **map falling in any state:** go to IDLE next cycle. Clear all counters and flags, suppress any pending pulse, note_addr=0.
- **Reset mid-song:** identical to power-up reset.

Test Plan:
- Bench parameters: TICK_DIV=2, NOTE_PERIOD=8, HIT_WINDOW=2, NOTE_COUNT=4, RECOVER_HITS=2.
- Note 0 lane 2, key_hit=4'b0100 at phase 6 → hit=1 for one cycle; hit_count=1, combo=1; no miss in slot 0.
- Note 0 lane 1, no key → exactly one miss pulse, one cycle after the phase-7 tick; combo=0. note_addr=1 during the following FETCH; slot length 17 cycles.
- Key 4'b0011 against lane 0 in the window → miss. A second, correct press later in the same window → no further pulse. A press at phase 3 → ignored.
- master=1: correct key at phase 6 → ignored, then miss at slot end. Correct key at phase 7 → hit.
- chance=1 with two consecutive hits → recover pulses once, one cycle after the second hit. Hit, miss, hit sequence → no recover.
- Four notes with rest at entry 3 → done rises after the slot-3 tick and stays high. map=0 → IDLE next cycle with done=0, note_addr=0, hit_count=0. Asserting map=0 mid-slot behaves the same.
